// File: rtl/fp_addsub_issue_if.sv
// Request, adder and response handshake bundle around fp_addsub_issue.
// slave is the controller's view; master is the surrounding decode/adder/writeback view.
interface fp_addsub_issue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_sub;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             add_start;
    logic             add_sub;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_y;
    logic [4:0]       add_flags;
    logic             add_valid;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_y;
    logic [4:0]       resp_flags;
    logic [TAG_W-1:0] resp_tag;

    modport slave (
        input  req_valid, req_sub, req_a, req_b, req_tag,
        output req_ready,
        output add_start, add_sub, add_a, add_b,
        input  add_y, add_flags, add_valid,
        output resp_valid, resp_y, resp_flags, resp_tag,
        input  resp_ready
    );

    modport master (
        output req_valid, req_sub, req_a, req_b, req_tag,
        input  req_ready,
        input  add_start, add_sub, add_a, add_b,
        output add_y, add_flags, add_valid,
        input  resp_valid, resp_y, resp_flags, resp_tag,
        output resp_ready
    );
endinterface

// File: rtl/fp_addsub_issue.sv
// Issue/retire controller in front of the FP add/sub unit: NaN/Inf/zero-zero resolved locally,
// the rest issued to the adder. Optional flush port and stale-result drop: FP_ADDSUB_FLUSH_EN.
module fp_addsub_issue #(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FP_ADDSUB_FLUSH_EN
    input  logic             flush,
`endif
    fp_addsub_issue_if.slave bus,
    input  logic             fflags_clr,
    output logic [4:0]       fflags_acc,
    output logic             timeout_err
);
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  FLG_NV    = 5'b10000;
    localparam logic [4:0]  FLG_OF_NX = 5'b00101;
    localparam int          CNT_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             accept, retire, timeout_hit, kill, idle_ok;
    logic             spec_hit;
    logic [31:0]      spec_y;
    logic [4:0]       spec_flags;
    logic [CNT_W-1:0] wait_cnt;

    logic             sub_q;
    logic [31:0]      a_q, b_q, y_q;
    logic [4:0]       flags_q;
    logic [TAG_W-1:0] tag_q;

    // Operand classification; b is seen with its effective sign after SUB.
    logic sb_eff, a_exp_max, b_exp_max, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    assign sb_eff    = bus.req_b[31] ^ bus.req_sub;
    assign a_exp_max = &bus.req_a[30:23];
    assign b_exp_max = &bus.req_b[30:23];
    assign a_nan     = a_exp_max && (bus.req_a[22:0] != 23'd0);
    assign b_nan     = b_exp_max && (bus.req_b[22:0] != 23'd0);
    assign a_snan    = a_nan && !bus.req_a[22];
    assign b_snan    = b_nan && !bus.req_b[22];
    assign a_inf     = a_exp_max && (bus.req_a[22:0] == 23'd0);
    assign b_inf     = b_exp_max && (bus.req_b[22:0] == 23'd0);
    assign a_zero    = (bus.req_a[30:0] == 31'd0);
    assign b_zero    = (bus.req_b[30:0] == 31'd0);

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        spec_hit   = 1'b1;
        spec_y     = QNAN;
        spec_flags = 5'd0;
        if (a_nan || b_nan) begin
            spec_flags = (a_snan || b_snan) ? FLG_NV : 5'd0;
        end else if (a_inf && b_inf && (bus.req_a[31] != sb_eff)) begin
            spec_flags = FLG_NV;
        end else if (a_inf) begin
            spec_y = bus.req_a;
        end else if (b_inf) begin
            spec_y = {sb_eff, bus.req_b[30:0]};
        end else if (a_zero && b_zero) begin
            spec_y = {bus.req_a[31] & sb_eff, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

`ifdef FP_ADDSUB_FLUSH_EN
    // A flushed op still in the adder returns one stale result that must be swallowed.
    logic drop_pending;
    assign kill    = flush;
    assign idle_ok = !drop_pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_pending <= 1'b0;
        end else if (flush && (state == ISSUE || (state == WAIT && !bus.add_valid))) begin
            drop_pending <= 1'b1;
        end else if (bus.add_valid) begin
            drop_pending <= 1'b0;
        end
    end
`else
    assign kill    = 1'b0;
    assign idle_ok = 1'b1;
`endif

    assign accept      = bus.req_valid && bus.req_ready && !kill;
    assign retire      = (state == RESP) && bus.resp_ready && !kill;
    assign timeout_hit = (state == WAIT) && !bus.add_valid && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = spec_hit ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.add_valid || timeout_hit) state_nxt = RESP;
            RESP:    if (retire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_comb begin
        bus.req_ready  = (state == IDLE) && idle_ok;
        bus.add_start  = (state == ISSUE);
        bus.resp_valid = (state == RESP);
    end

    // NOTE: datapath registers are reset as well, because their zero value is visible on the ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sub_q       <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            y_q         <= 32'd0;
            flags_q     <= 5'd0;
            tag_q       <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            fflags_acc  <= 5'd0;
        end else begin
            timeout_err <= 1'b0;
            if (accept) begin
                sub_q <= bus.req_sub;
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                tag_q <= bus.req_tag;
                if (spec_hit) begin
                    y_q     <= spec_y;
                    flags_q <= spec_flags;
                end
            end

            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

            // Adder overflow encoding is replaced by a signed infinity.
            if (state == WAIT && bus.add_valid) begin
                if (bus.add_flags[2]) begin
                    y_q     <= {bus.add_y[31], 8'hFF, 23'd0};
                    flags_q <= bus.add_flags | FLG_OF_NX;
                end else begin
                    y_q     <= bus.add_y;
                    flags_q <= bus.add_flags;
                end
            end else if (timeout_hit) begin
                y_q         <= QNAN;
                flags_q     <= FLG_NV;
                timeout_err <= !kill;
            end

            fflags_acc <= (fflags_clr ? 5'd0 : fflags_acc) | (retire ? flags_q : 5'd0);
        end
    end

    assign bus.add_sub    = sub_q;
    assign bus.add_a      = a_q;
    assign bus.add_b      = b_q;
    assign bus.resp_y     = y_q;
    assign bus.resp_flags = flags_q;
    assign bus.resp_tag   = tag_q;
endmodule

// File: tb/tb_fp_addsub_issue.sv
// Self-checking bench for fp_addsub_issue: directed cases from the op rules plus randomized
// back-to-back traffic against a classification-based reference model and a simple adder model.
module tb_fp_addsub_issue;
    localparam int          TAG_W       = 5;
    localparam int          TIMEOUT_CYC = 15;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF     = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF     = 32'hFF80_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fflags_clr = 1'b0;
    logic [4:0] fflags_acc;
    logic       timeout_err;
`ifdef FP_ADDSUB_FLUSH_EN
    logic       flush = 1'b0;
`endif

    fp_addsub_issue_if #(.TAG_W(TAG_W)) bus ();

    fp_addsub_issue #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FP_ADDSUB_FLUSH_EN
        .flush       (flush),
`endif
        .bus         (bus),
        .fflags_clr  (fflags_clr),
        .fflags_acc  (fflags_acc),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [4:0] exp_acc = 5'd0;

    // Adder model: answers one cycle after add_start with preloaded y/flags when enabled.
    bit          mdl_en = 1'b1;
    logic [31:0] mdl_y = 32'd0;
    logic [4:0]  mdl_flags = 5'd0;
    bit          late_pulse = 1'b0;
    int          start_cnt = 0;

    always @(posedge clk) begin
        bus.add_valid <= ((bus.add_start === 1'b1) && mdl_en) || late_pulse;
        if (bus.add_start === 1'b1) begin
            bus.add_y     <= mdl_y;
            bus.add_flags <= mdl_flags;
            start_cnt     <= start_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    typedef enum {C_ZERO, C_FIN, C_INF, C_QNAN, C_SNAN} cls_t;

    function automatic cls_t classify(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? C_INF : (x[22] ? C_QNAN : C_SNAN);
        return (x[30:0] == 31'd0) ? C_ZERO : C_FIN;
    endfunction

    // Reference for locally resolved ops; hit=0 means the op must go to the adder.
    task automatic ref_special(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               output bit hit, output logic [31:0] y, output logic [4:0] f);
        cls_t ca, cb;
        logic sb;
        ca  = classify(a);
        cb  = classify(b);
        sb  = b[31] ^ sub;
        hit = 1'b1;
        y   = QNAN;
        f   = 5'd0;
        if (ca inside {C_QNAN, C_SNAN} || cb inside {C_QNAN, C_SNAN}) begin
            f = (ca == C_SNAN || cb == C_SNAN) ? 5'b10000 : 5'd0;
        end else if (ca == C_INF && cb == C_INF) begin
            if (a[31] == sb) y = a;
            else             f = 5'b10000;
        end else if (ca == C_INF) begin
            y = a;
        end else if (cb == C_INF) begin
            y = sb ? NEG_INF : POS_INF;
        end else if (ca == C_ZERO && cb == C_ZERO) begin
            y = (a[31] && sb) ? 32'h8000_0000 : 32'h0000_0000;
        end else begin
            hit = 1'b0;
        end
    endtask

    // One complete op: accept, latency, response contents, backpressure hold, retire, fflags.
    // Latency is counted in clock edges from the accept edge to the edge that raises resp_valid.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [TAG_W-1:0] tag, input int hold,
                          input bit clr_at_retire);
        bit          hit, tmo;
        logic [31:0] ey;
        logic [4:0]  ef;
        int          exp_k, k, starts0;
        ref_special(a, b, sub, hit, ey, ef);
        tmo = !hit && !mdl_en;
        if (!hit) begin
            if (tmo) begin
                ey = QNAN;
                ef = 5'b10000;
            end else if (mdl_flags[2]) begin
                ey = mdl_y[31] ? NEG_INF : POS_INF;
                ef = mdl_flags | 5'b00101;
            end else begin
                ey = mdl_y;
                ef = mdl_flags;
            end
        end
        exp_k   = hit ? 0 : (tmo ? 1 + TIMEOUT_CYC : 2);
        starts0 = start_cnt;

        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        bus.req_tag   = tag;
        step();
        bus.req_valid = 1'b0;

        checks++;
        if (bus.add_start !== logic'(!hit)) begin
            failures++;
            $display("FAIL %s add_start: got %b want %b", name, bus.add_start, !hit);
        end

        k = 0;
        while (bus.resp_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k != exp_k) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, k, exp_k);
        end
        if (bus.resp_valid !== 1'b1) return;

        checks++;
        if (bus.resp_y !== ey || bus.resp_flags !== ef || bus.resp_tag !== tag) begin
            failures++;
            $display("FAIL %s resp: got y=%h f=%b tag=%0d want y=%h f=%b tag=%0d",
                     name, bus.resp_y, bus.resp_flags, bus.resp_tag, ey, ef, tag);
        end
        checks++;
        if (timeout_err !== logic'(tmo)) begin
            failures++;
            $display("FAIL %s timeout_err: got %b want %b", name, timeout_err, tmo);
        end

        for (int h = 0; h < hold; h++) begin
            bus.resp_ready = 1'b0;
            step();
            checks++;
            if ({bus.resp_valid, bus.req_ready, timeout_err, bus.resp_y, bus.resp_flags, bus.resp_tag}
                !== {1'b1, 1'b0, 1'b0, ey, ef, tag}) begin
                failures++;
                $display("FAIL %s hold%0d: got v=%b rdy=%b to=%b y=%h f=%b tag=%0d want v=1 rdy=0 to=0 y=%h f=%b tag=%0d",
                         name, h, bus.resp_valid, bus.req_ready, timeout_err, bus.resp_y,
                         bus.resp_flags, bus.resp_tag, ey, ef, tag);
            end
        end

        bus.resp_ready = 1'b1;
        fflags_clr     = clr_at_retire;
        step();
        bus.resp_ready = 1'b0;
        fflags_clr     = 1'b0;
        exp_acc        = (clr_at_retire ? 5'd0 : exp_acc) | ef;

        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL %s retire: got v=%b rdy=%b to=%b want v=0 rdy=1 to=0",
                     name, bus.resp_valid, bus.req_ready, timeout_err);
        end
        checks++;
        if (fflags_acc !== exp_acc) begin
            failures++;
            $display("FAIL %s fflags_acc: got %b want %b", name, fflags_acc, exp_acc);
        end
        checks++;
        if (start_cnt - starts0 != (hit ? 0 : 1)) begin
            failures++;
            $display("FAIL %s start_count: got %0d want %0d", name, start_cnt - starts0, hit ? 0 : 1);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({bus.resp_valid, bus.add_start, timeout_err, fflags_acc, bus.resp_y, bus.resp_flags,
             bus.resp_tag, bus.add_a, bus.add_b, bus.add_sub} !== '0) begin
            failures++;
            $display("FAIL %s zero_outputs: got v=%b st=%b to=%b acc=%b y=%h f=%b tag=%0d a=%h b=%h sub=%b want all 0",
                     name, bus.resp_valid, bus.add_start, timeout_err, fflags_acc, bus.resp_y,
                     bus.resp_flags, bus.resp_tag, bus.add_a, bus.add_b, bus.add_sub);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        check_zero_outputs("reset");
        rst = 1'b1;
        step();
        exp_acc = 5'd0;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset req_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_basic_add();
        mdl_en    = 1'b1;
        mdl_y     = 32'h4040_0000;
        mdl_flags = 5'd0;
        run_op("add_1p2", 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 0, 1'b0);
    endtask

    task automatic test_specials();
        run_op("inf_sub_inf", POS_INF, POS_INF, 1'b1, 5'd4, 0, 1'b0);
        run_op("snan_add", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 5'd5, 0, 1'b0);
        run_op("qnan_add", 32'h3F80_0000, 32'hFFC0_1234, 1'b0, 5'd6, 0, 1'b0);
        run_op("zero_p_negzero", 32'h0000_0000, 32'h8000_0000, 1'b0, 5'd7, 0, 1'b0);
        run_op("negzero_sub_zero", 32'h8000_0000, 32'h0000_0000, 1'b1, 5'd8, 0, 1'b0);
        run_op("fin_sub_inf", 32'h4120_0000, POS_INF, 1'b1, 5'd9, 0, 1'b0);
    endtask

    task automatic test_overflow();
        mdl_en    = 1'b1;
        mdl_y     = 32'h7F7F_FFFF;
        mdl_flags = 5'b00101;
        run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd10, 0, 1'b0);
        mdl_y     = 32'hFF12_3456;
        mdl_flags = 5'b00100;
        run_op("overflow_neg", 32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 5'd11, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        mdl_en    = 1'b1;
        mdl_y     = 32'h4110_0000;
        mdl_flags = 5'b00001;
        run_op("backpressure", 32'h4080_0000, 32'h40A0_0000, 1'b0, 5'd12, 5, 1'b0);
        run_op("backpressure_spec", NEG_INF, 32'h3F80_0000, 1'b0, 5'd13, 5, 1'b0);
    endtask

    task automatic test_timeout();
        mdl_en = 1'b0;
        run_op("timeout", 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd14, 1, 1'b0);
        mdl_en = 1'b1;
    endtask

    task automatic test_fflags_clr();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        exp_acc    = 5'd0;
        checks++;
        if (fflags_acc !== 5'd0) begin
            failures++;
            $display("FAIL fflags_clr_alone: got %b want 00000", fflags_acc);
        end
        mdl_en    = 1'b1;
        mdl_y     = 32'h7F7F_FFFF;
        mdl_flags = 5'b00101;
        run_op("acc_of", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd15, 0, 1'b0);
        run_op("acc_clr_nv", POS_INF, NEG_INF, 1'b0, 5'd16, 0, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        int starts0;
        mdl_en = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_a     = 32'h3F80_0000;
        bus.req_b     = 32'h4000_0000;
        bus.req_sub   = 1'b0;
        bus.req_tag   = 5'd17;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_acc = 5'd0;
        check_zero_outputs("reset_mid_wait");
        starts0    = start_cnt;
        late_pulse = 1'b1;
        step();
        late_pulse = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || timeout_err !== 1'b0
            || start_cnt != starts0) begin
            failures++;
            $display("FAIL late_add_valid: got v=%b rdy=%b to=%b starts=%0d want v=0 rdy=1 to=0 starts=%0d",
                     bus.resp_valid, bus.req_ready, timeout_err, start_cnt, starts0);
        end
        mdl_en    = 1'b1;
        mdl_y     = 32'h4040_0000;
        mdl_flags = 5'd0;
        run_op("after_reset", 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd18, 0, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            3:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic test_back_to_back();
        mdl_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mdl_y     = $urandom;
            mdl_flags = 5'($urandom);
            run_op($sformatf("rand%0d", i), rand_operand(), rand_operand(),
                   1'($urandom_range(0, 1)), TAG_W'($urandom), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_sub    = 1'b0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_specials();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_fflags_clr();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
